// File: rtl/video_timing_fmt.sv
// Video timing generator and pixel formatter: raster counters, look-ahead pixel
// requests, and a short pipeline that aligns sync/enable with formatted pixel data.
module video_timing_fmt #(
  parameter int H_DISP   = 1280,
  parameter int H_FRONT  = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int V_DISP   = 720,
  parameter int V_FRONT  = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int REQ_LEAD = 1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [1:0]  mode,
  input  logic [15:0] pixel_data,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [11:0] H_SYNC_E = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_E = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_S  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_E  = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] V_ACT_S  = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_E  = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] BAR_W    = 12'(H_DISP / 8);

  // One pipeline entry: everything the output stage needs about a raster position.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [1:0] mode;
    logic [2:0] bar;
  } pipe_t;

  logic [11:0] h_cnt, v_cnt;
  logic [11:0] h_nxt, v_nxt;
  logic        h_act, h_act_n, v_act_n, req_n;
  logic        frame_start;
  logic        first_frame;
  logic [1:0]  mode_q;
  logic [11:0] bar_sub;
  logic [2:0]  bar_idx;
  pipe_t       stage_c;
  pipe_t       tail;

  always_comb begin
    h_nxt = h_cnt + 12'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_TOTAL - 12'd1) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_TOTAL - 12'd1) ? '0 : v_cnt + 12'd1;
    end
  end

  assign h_act       = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
  assign h_act_n     = (h_nxt >= H_ACT_S) && (h_nxt < H_ACT_E);
  assign v_act_n     = (v_nxt >= V_ACT_S) && (v_nxt < V_ACT_E);
  assign req_n       = h_act_n && v_act_n;
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  // Request outputs are registered from the next counter values so that
  // data_req and the coordinates describe the position held in h_cnt/v_cnt.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      data_req    <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      mode_q      <= '0;
      frame_cnt   <= '0;
      first_frame <= 1'b1;
    end else begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      data_req   <= req_n;
      pixel_xpos <= req_n ? 11'(h_nxt - H_ACT_S) : '0;
      pixel_ypos <= req_n ? 11'(v_nxt - V_ACT_S) : '0;
      if (frame_start) begin
        mode_q <= mode;
        if (first_frame) first_frame <= 1'b0;
        else             frame_cnt   <= frame_cnt + 16'd1;
      end
    end
  end

  // Colour-bar index tracks x of the current position without a divider.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      bar_sub <= '0;
      bar_idx <= '0;
    end else if (h_nxt == H_ACT_S) begin
      bar_sub <= '0;
      bar_idx <= '0;
    end else if (h_act) begin
      if (bar_sub == BAR_W - 12'd1) begin
        bar_sub <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_sub <= bar_sub + 12'd1;
      end
    end
  end

  always_comb begin
    stage_c      = '0;
    stage_c.de   = data_req;
    stage_c.hs   = (h_cnt < H_SYNC_E);
    stage_c.vs   = (v_cnt < V_SYNC_E);
    stage_c.mode = mode_q;
    stage_c.bar  = bar_idx;
  end

  // The mode travels with each position, so in-flight pixels keep their frame's format.
  if (REQ_LEAD == 0) begin : g_no_lead
    assign tail = stage_c;
  end else begin : g_lead
    pipe_t pipe_q [REQ_LEAD];
    always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
        for (int i = 0; i < REQ_LEAD; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= stage_c;
        for (int i = 1; i < REQ_LEAD; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign tail = pipe_q[REQ_LEAD-1];
  end

  function automatic logic [23:0] fmt_pixel(input logic [15:0] p, input logic [1:0] m,
                                            input logic [2:0] bar);
    fmt_pixel = '0;
    case (m)
      2'd0:    fmt_pixel = {p[15:11], 3'b0, p[10:5], 2'b0, p[4:0], 3'b0};
      2'd1:    fmt_pixel = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
      2'd2:    fmt_pixel = {3{p[7:0]}};
      default: fmt_pixel = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    endcase
  endfunction

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      video_de  <= 1'b0;
      video_hs  <= ~HS_POL;
      video_vs  <= ~VS_POL;
      video_rgb <= '0;
    end else begin
      video_de  <= tail.de;
      video_hs  <= tail.hs ? HS_POL : ~HS_POL;
      video_vs  <= tail.vs ? VS_POL : ~VS_POL;
      video_rgb <= tail.de ? fmt_pixel(pixel_data, tail.mode, tail.bar) : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_fmt.sv
// Bench for video_timing_fmt: two small-raster instances (lead 1 and lead 3)
// compared every cycle against a position-arithmetic reference model.
module tb_video_timing_fmt;

  localparam int HT = 25;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;
  localparam int H_ACT = 7;
  localparam int V_ACT = 2;
  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst;
  logic [1:0]  mode;
  logic [15:0] pixel_data_a, pixel_data_b;
  logic        data_req_a, data_req_b;
  logic [10:0] xpos_a, ypos_a, xpos_b, ypos_b;
  logic        hs_a, vs_a, de_a, hs_b, vs_b, de_b;
  logic [23:0] rgb_a, rgb_b;
  logic [15:0] fcnt_a, fcnt_b;

  video_timing_fmt #(
    .H_DISP(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1)
  ) dut_a (
    .pixel_clk(clk), .sys_rst(sys_rst), .mode(mode), .pixel_data(pixel_data_a),
    .data_req(data_req_a), .pixel_xpos(xpos_a), .pixel_ypos(ypos_a),
    .video_hs(hs_a), .video_vs(vs_a), .video_de(de_a), .video_rgb(rgb_a),
    .frame_cnt(fcnt_a)
  );

  video_timing_fmt #(
    .H_DISP(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(3)
  ) dut_b (
    .pixel_clk(clk), .sys_rst(sys_rst), .mode(mode), .pixel_data(pixel_data_b),
    .data_req(data_req_b), .pixel_xpos(xpos_b), .pixel_ypos(ypos_b),
    .video_hs(hs_b), .video_vs(vs_b), .video_de(de_b), .video_rgb(rgb_b),
    .frame_cnt(fcnt_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  logic [15:0] pix_hist [0:4095];
  int          xobs [0:4095];
  int          frame_mode [0:15];
  int          plan_mode [0:15];
  int          plan_mid [0:15];
  int          plan_pix [0:15];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  function automatic bit in_act(input int h, input int v);
    return (h >= H_ACT) && (h < H_ACT + 16) && (v >= V_ACT) && (v < V_ACT + 4);
  endfunction

  function automatic logic [23:0] fmt_model(input int p, input int m, input int x);
    int r, g, b, lo;
    r  = (p >> 11) & 31;
    g  = (p >> 5) & 63;
    b  = p & 31;
    lo = p & 255;
    case (m)
      0:       return {8'(r * 8), 8'(g * 4), 8'(b * 8)};
      1:       return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
      2:       return {8'(lo), 8'(lo), 8'(lo)};
      default: return BAR_TAB[x / 2];
    endcase
  endfunction

  task automatic check_cycle();
    int h, v, f, q;
    bit de;
    logic [23:0] rgb_exp;
    // request side, position k
    h = k % HT; v = (k / HT) % VT;
    de = in_act(h, v);
    check_val("a_req", data_req_a, de);
    check_val("a_xpos", xpos_a, de ? h - H_ACT : 0);
    check_val("a_ypos", ypos_a, de ? v - V_ACT : 0);
    check_val("b_req", data_req_b, de);
    check_val("a_fcnt", fcnt_a, (k == 0) ? 0 : (k - 1) / FRAME);
    check_val("b_fcnt", fcnt_b, (k == 0) ? 0 : (k - 1) / FRAME);
    // video side of instance a, two cycles behind the counters
    q = k - 2;
    if (q < 0) begin
      check_val("a_de", de_a, 0); check_val("a_hs", hs_a, 0);
      check_val("a_vs", vs_a, 0); check_val("a_rgb", rgb_a, 0);
    end else begin
      h = q % HT; v = (q / HT) % VT; f = q / FRAME;
      de = in_act(h, v);
      rgb_exp = de ? fmt_model(int'(pix_hist[k-1]), frame_mode[f], h - H_ACT) : 24'h0;
      check_val("a_de", de_a, de); check_val("a_hs", hs_a, h < 3);
      check_val("a_vs", vs_a, v < 1); check_val("a_rgb", rgb_a, rgb_exp);
    end
    // video side of instance b (active-low syncs), four cycles behind
    q = k - 4;
    if (q < 0) begin
      check_val("b_de", de_b, 0); check_val("b_hs", hs_b, 1);
      check_val("b_vs", vs_b, 1); check_val("b_rgb", rgb_b, 0);
    end else begin
      h = q % HT; v = (q / HT) % VT; f = q / FRAME;
      de = in_act(h, v);
      rgb_exp = de ? fmt_model(h - H_ACT, frame_mode[f], h - H_ACT) : 24'h0;
      check_val("b_de", de_b, de); check_val("b_hs", hs_b, !(h < 3));
      check_val("b_vs", vs_b, !(v < 1)); check_val("b_rgb", rgb_b, rgb_exp);
    end
  endtask

  task automatic run_cycle(input bit rst_now);
    int f, pos;
    f = k / FRAME;
    pos = k % FRAME;
    sys_rst = rst_now;
    mode = 2'((pos < 60) ? plan_mode[f] : plan_mid[f]);
    case (plan_pix[f])
      1:       pixel_data_a = 16'hFFFF;
      2:       pixel_data_a = 16'h00A5;
      default: pixel_data_a = 16'($urandom);
    endcase
    pixel_data_b = (k >= 3) ? 16'(xobs[k-3]) : 16'h0;
    if (pos == 0) frame_mode[f] = int'(mode);
    @(negedge clk);
    pix_hist[k] = pixel_data_a;
    xobs[k] = int'(xpos_b);
    check_cycle();
    @(posedge clk);
    #1;
    if (rst_now) k = 0;
    else k++;
  endtask

  initial begin
    plan_mode[0] = 0; plan_mid[0] = 3; plan_pix[0] = 0;
    plan_mode[1] = 3; plan_mid[1] = 1; plan_pix[1] = 0;
    plan_mode[2] = 1; plan_mid[2] = 2; plan_pix[2] = 1;
    plan_mode[3] = 0; plan_mid[3] = 0; plan_pix[3] = 1;
    plan_mode[4] = 2; plan_mid[4] = 3; plan_pix[4] = 2;
    for (int i = 5; i < 16; i++) begin
      plan_mode[i] = $urandom_range(0, 3);
      plan_mid[i]  = $urandom_range(0, 3);
      plan_pix[i]  = 0;
    end
    sys_rst = 1'b1;
    mode = 2'd0;
    pixel_data_a = 16'h0;
    pixel_data_b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    k = 0;
    for (int i = 0; i < 7 * FRAME + 40; i++) run_cycle(1'b0);
    run_cycle(1'b1);
    for (int i = 0; i < 3 * FRAME; i++) run_cycle(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_timing_fmt.md
# video_timing_fmt

Parametrised video timing generator and pixel formatter. It is the next-generation front end of the HDMI output path: it sits between the frame-buffer read side (`data_req` / `pixel_data`) and the DVI/TMDS transmitter (`video_hs` / `video_vs` / `video_de` / `video_rgb`). Resolution, porches, sync polarity and request lead are set by parameters. A frame-latched mode input selects RGB565 zero-pad, RGB565 MSB-replicate, 8-bit grey, or an internal colour-bar pattern.

## Interface
- `H_DISP`, 1280, active pixels per line; must be a multiple of 8.
- `H_FRONT`, 110, horizontal front porch, in pixels.
- `H_SYNC`, 40, hsync width, in pixels.
- `H_BACK`, 220, horizontal back porch, in pixels.
- `V_DISP`, 720, active lines.
- `V_FRONT`, 5, vertical front porch, in lines.
- `V_SYNC`, 5, vsync width, in lines.
- `V_BACK`, 20, vertical back porch, in lines.
- `HS_POL`, 1, active level of `video_hs`.
- `VS_POL`, 1, active level of `video_vs`.
- `REQ_LEAD`, 1, cycles from `data_req` to valid `pixel_data`; range 0..4.
- `pixel_clk` in 1: sole clock; all logic is on its rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `mode` in 2: pixel format select; sampled only at frame start.
- `pixel_data` in 16: source pixel.
- `data_req` out 1: pixel request.
- `pixel_xpos` out 11: x coordinate of the requested pixel; 0 when `data_req` is low.
- `pixel_ypos` out 11: y coordinate of the requested pixel; 0 when `data_req` is low.
- `video_hs` out 1: horizontal sync.
- `video_vs` out 1: vertical sync.
- `video_de` out 1: data enable.
- `video_rgb` out 24: pixel as {R8,G8,B8}.
- `frame_cnt` out 16: completed-frame count; wraps.

## Operation
- Counters:
  - `H_TOTAL` = `H_SYNC`+`H_BACK`+`H_DISP`+`H_FRONT`.
  - `V_TOTAL` is the same sum of the V parameters.
  - `h_cnt` runs 0..`H_TOTAL`-1 and wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps, and wraps at `V_TOTAL`-1.
- Region order in each dimension: sync, then back porch, then active, then front porch.
  - Sync: `h_cnt` < `H_SYNC`.
  - Active: `h_cnt` in [`H_SYNC`+`H_BACK`, `H_SYNC`+`H_BACK`+`H_DISP`).
  - The same rules apply vertically.
- Internal `de_i` = horizontal active AND vertical active.
- `data_req` is `de_i` advanced by `REQ_LEAD`+1 cycles, computed from the counters rather than by delay. Each active line therefore gives exactly `H_DISP` request cycles.
- `pixel_xpos` / `pixel_ypos` give the coordinate of the pixel requested in that cycle, 0..`H_DISP`-1 and 0..`V_DISP`-1.
- Frame start is defined as `h_cnt`==0 and `v_cnt`==0. On frame start:
  - `mode` is latched into `mode_q`.
  - If the count is not in the first frame after reset, `frame_cnt` increments. It wraps 0xFFFF -> 0.
- Format conversion (R=`p[15:11]`, G=`p[10:5]`, B=`p[4:0]`):
  - `mode_q` 0: {R,3'b0, G,2'b0, B,3'b0}.
  - `mode_q` 1: {R,R[4:2], G,G[5:4], B,B[4:2]}; 0xFFFF maps to 0xFFFFFF.
  - `mode_q` 2: `p[7:0]` replicated to all three channels.
  - `mode_q` 3: colour bars; `pixel_data` is ignored.
    - Bar index = x / (`H_DISP`/8), produced by a per-line counter, not a divider.
    - Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black, with each channel 0x00 or 0xFF.
- Outside active video, `video_rgb` = 0.
- `data_req` stays asserted in mode 3; the source may ignore it.

## Timing
- Reset is synchronous. On the cycle after `sys_rst` is sampled high:
  - `h_cnt`, `v_cnt`, `frame_cnt`, `mode_q` and `video_rgb` are 0.
  - `data_req`, `video_de`, `pixel_xpos` and `pixel_ypos` are 0.
  - `video_hs` = !`HS_POL`.
  - `video_vs` = !`VS_POL`.
- Reset mid-frame aborts the frame. After release, the first cycle is `h_cnt`=0, `v_cnt`=0, which is a frame start.
- `data_req` high in cycle t means `pixel_data` is sampled at t+`REQ_LEAD`. The corresponding `video_de`=1 and `video_rgb` appear at t+`REQ_LEAD`+1; all outputs are registered.
- `video_hs` and `video_vs` share the pipeline delay of `video_de`: all three outputs are mutually aligned, as required by the transmitter.
- `mode` changes take effect only on the first pixel of the next frame. No frame mixes formats.
- A `mode` change coincident with frame start is captured for that frame.

## Test plan
- Small timing (`H_DISP`=16, `H_FRONT`=2, `H_SYNC`=3, `H_BACK`=4, `V_DISP`=4, `V_FRONT`=1, `V_SYNC`=1, `V_BACK`=1, `REQ_LEAD`=1), run 2 frames:
  - hs high 3 of 25 cycles per line.
  - de is 16 consecutive cycles starting at line offset 7+2 (pipeline delay).
  - 4 active lines per 7-line frame.
  - `frame_cnt`=1.
- `REQ_LEAD`=3, `pixel_data` = x echoed from a delayed `pixel_xpos`, mode 0: `video_rgb` carries the sequence x=0..15 in order, with no skipped or duplicated pixel.
- Mode 1 with `pixel_data`=0xFFFF -> 0xFFFFFF. Mode 0 with the same input -> 0xF8FCF8. Mode 2 with 0x00A5 -> 0xA5A5A5.
- Mode 3, `H_DISP`=16: bars are 2 pixels wide. x=0,1 -> 0xFFFFFF; x=2 -> 0xFFFF00; x=14,15 -> 0x000000.
- Toggle `mode` from 0 to 3 mid-frame: the current frame stays mode 0 throughout; the next frame is colour bars from its first pixel.
- Assert `sys_rst` for 1 cycle mid-line:
  - Next cycle: all outputs at their reset values.
  - `frame_cnt`=0.
  - The first de appears after the full sync + back-porch interval.
